gen_mod_sched: RTL and testbench

Scheduler/configurator for the harmonic modulation generator.
- Owns the generator's `hp` (harmonic period) and `phase` inputs and its synchronous reset.
- Applies host configuration only at safe points: an `hp` change restarts the generator; a `phase` change takes effect at a period boundary (`harmonic_trig`).
- Provides an autonomous phase-sweep sequencer that steps phase every N periods, used for lock-in phase scans.

---
 rtl/gen_mod_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_gen_mod_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_mod_sched.sv
// gen_mod_sched: hp/phase scheduler and phase-sweep sequencer for the harmonic modulation generator.
// Defining GEN_MOD_SCHED_WDOG_EN adds a period watchdog on APPLY/SWEEP and the wdog_err output.
//
// state   | meaning
// IDLE    | accepts cfg_wr (once gen_rst hold has ended) and sweep_start
// RESTART | new hp/phase loaded, gen_rst held for RST_CYC cycles
// APPLY   | pending phase waits for the next harmonic_trig
// SWEEP   | phase stepped every max(sweep_dwell,1) periods up to the clamped end
module gen_mod_sched #(
  parameter int PERIOD_LEN = 120,
  parameter int RST_CYC    = 2,
  parameter int DWELL_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [13:0]        cfg_hp,
  input  logic [11:0]        cfg_phase,
  input  logic               cfg_wr,
  input  logic               sweep_start,
  input  logic               sweep_stop,
  input  logic [11:0]        sweep_step,
  input  logic [11:0]        sweep_end,
  input  logic [DWELL_W-1:0] sweep_dwell,
  input  logic               harmonic_trig,
  output logic [13:0]        hp,
  output logic [11:0]        phase,
  output logic               gen_rst,
  output logic               busy,
  output logic               cfg_err,
  output logic               step_pulse,
  output logic               sweep_done,
  output logic [1:0]         state
`ifdef GEN_MOD_SCHED_WDOG_EN
  ,
  output logic               wdog_err
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTART = 2'd1,
    APPLY   = 2'd2,
    SWEEP   = 2'd3
  } state_t;

  localparam int HOLD_W = $clog2(RST_CYC + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYC);
  localparam logic [11:0] PH_MAX = 12'(PERIOD_LEN - 1);

  state_t              st_q, st_nxt;
  logic [13:0]         hp_q, hp_nxt;
  logic [11:0]         phase_q, phase_nxt;
  logic [13:0]         pend_hp_q, pend_hp_nxt;
  logic [11:0]         pend_phase_q, pend_phase_nxt;
  logic [HOLD_W-1:0]   hold_q, hold_nxt;
  logic [DWELL_W-1:0]  dwell_q, dwell_nxt;
  logic                cfg_err_q, cfg_err_nxt;
  logic                step_q, step_nxt;
  logic                done_q, done_nxt;

  logic                accept;
  logic [11:0]         cfg_ph_sat;
  logic [DWELL_W-1:0]  dwell_lim;
  logic [DWELL_W:0]    dwell_inc;
  logic                dwell_exp;
  logic [11:0]         lim;
  logic [12:0]         ph_sum;
  logic [11:0]         ph_step;
  logic                at_lim;

  assign accept     = (st_q == IDLE) && (hold_q == '0);
  assign cfg_ph_sat = (cfg_phase > PH_MAX) ? PH_MAX : cfg_phase;
  assign dwell_lim  = (sweep_dwell == '0) ? DWELL_W'(1) : sweep_dwell;
  assign dwell_inc  = {1'b0, dwell_q} + (DWELL_W + 1)'(1);
  assign dwell_exp  = dwell_inc >= {1'b0, dwell_lim};
  assign lim        = (sweep_end > PH_MAX) ? PH_MAX : sweep_end;
  assign ph_sum     = {1'b0, phase_q} + {1'b0, sweep_step};
  assign ph_step    = (ph_sum > {1'b0, lim}) ? lim : ph_sum[11:0];
  // a zero step can never advance, so it ends the sweep like reaching lim
  assign at_lim     = (phase_q == lim) || (sweep_step == '0);

`ifdef GEN_MOD_SCHED_WDOG_EN
  localparam int TICK_W = $clog2(2 * PERIOD_LEN + 1);
  localparam logic [TICK_W-1:0] TICK_INIT = TICK_W'(2 * PERIOD_LEN);

  logic [13:0]       pre_q;
  logic [TICK_W-1:0] tick_q;
  logic              wdog_q;
  logic              wd_active;
  logic              wd_fire;

  assign wd_active = (st_q == APPLY) || (st_q == SWEEP);
  assign wd_fire   = wd_active && !harmonic_trig && (pre_q == '0) && (tick_q == TICK_W'(1));
  assign wdog_err  = wdog_q;

  // pre_q divides clk by hp+1; tick_q counts those ticks down to expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= TICK_INIT;
      wdog_q <= 1'b0;
    end else begin
      wdog_q <= wd_fire;
      if (!wd_active || harmonic_trig || wd_fire) begin
        pre_q  <= hp_q;
        tick_q <= TICK_INIT;
      end else if (pre_q == '0) begin
        pre_q  <= hp_q;
        tick_q <= tick_q - TICK_W'(1);
      end else begin
        pre_q  <= pre_q - 14'd1;
      end
    end
  end
`endif

  always_comb begin
    st_nxt         = st_q;
    hp_nxt         = hp_q;
    phase_nxt      = phase_q;
    pend_hp_nxt    = pend_hp_q;
    pend_phase_nxt = pend_phase_q;
    hold_nxt       = (hold_q != '0) ? hold_q - HOLD_W'(1) : '0;
    dwell_nxt      = dwell_q;
    cfg_err_nxt    = cfg_wr && !accept;
    step_nxt       = 1'b0;
    done_nxt       = 1'b0;
    case (st_q)
      IDLE: begin
        if (cfg_wr && accept) begin
          pend_hp_nxt    = cfg_hp;
          pend_phase_nxt = cfg_ph_sat;
          if (cfg_hp != hp_q) begin
            st_nxt    = RESTART;
            hp_nxt    = cfg_hp;
            phase_nxt = cfg_ph_sat;
            hold_nxt  = HOLD_INIT;
          end else begin
            st_nxt = APPLY;
          end
        end else if (sweep_start) begin
          st_nxt    = SWEEP;
          dwell_nxt = '0;
        end
      end
      RESTART: begin
        hp_nxt    = pend_hp_q;
        phase_nxt = pend_phase_q;
        if (hold_q <= HOLD_W'(1)) st_nxt = IDLE;
      end
      APPLY: begin
        if (harmonic_trig) begin
          phase_nxt = pend_phase_q;
          st_nxt    = IDLE;
        end
      end
      SWEEP: begin
        if (sweep_stop) begin
          st_nxt    = IDLE;
          dwell_nxt = '0;
        end else if (harmonic_trig) begin
          if (dwell_exp) begin
            dwell_nxt = '0;
            if (at_lim) begin
              done_nxt = 1'b1;
              st_nxt   = IDLE;
            end else begin
              phase_nxt = ph_step;
              step_nxt  = 1'b1;
            end
          end else begin
            dwell_nxt = dwell_inc[DWELL_W-1:0];
          end
        end
      end
      default: st_nxt = IDLE;
    endcase
`ifdef GEN_MOD_SCHED_WDOG_EN
    if (wd_fire) begin
      st_nxt         = RESTART;
      hp_nxt         = hp_q;
      phase_nxt      = phase_q;
      pend_hp_nxt    = hp_q;
      pend_phase_nxt = phase_q;
      hold_nxt       = HOLD_INIT;
      dwell_nxt      = '0;
      step_nxt       = 1'b0;
      done_nxt       = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= IDLE;
      hp_q         <= '0;
      phase_q      <= '0;
      pend_hp_q    <= '0;
      pend_phase_q <= '0;
      hold_q       <= HOLD_INIT;
      dwell_q      <= '0;
      cfg_err_q    <= 1'b0;
      step_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      st_q         <= st_nxt;
      hp_q         <= hp_nxt;
      phase_q      <= phase_nxt;
      pend_hp_q    <= pend_hp_nxt;
      pend_phase_q <= pend_phase_nxt;
      hold_q       <= hold_nxt;
      dwell_q      <= dwell_nxt;
      cfg_err_q    <= cfg_err_nxt;
      step_q       <= step_nxt;
      done_q       <= done_nxt;
    end
  end

  assign hp         = hp_q;
  assign phase      = phase_q;
  assign gen_rst    = (hold_q != '0);
  assign busy       = (st_q != IDLE);
  assign cfg_err    = cfg_err_q;
  assign step_pulse = step_q;
  assign sweep_done = done_q;
  assign state      = st_q;

endmodule

// File: tb/tb_gen_mod_sched.sv
// Directed bench for gen_mod_sched: per-cycle vector table for config/reset paths,
// hand sequences for sweep, collisions and (when GEN_MOD_SCHED_WDOG_EN is defined) the watchdog.
module tb_gen_mod_sched;

  logic        clk;
  logic        rst;
  logic [13:0] cfg_hp;
  logic [11:0] cfg_phase;
  logic        cfg_wr;
  logic        sweep_start;
  logic        sweep_stop;
  logic [11:0] sweep_step;
  logic [11:0] sweep_end;
  logic [15:0] sweep_dwell;
  logic        harmonic_trig;
  logic [13:0] hp;
  logic [11:0] phase;
  logic        gen_rst;
  logic        busy;
  logic        cfg_err;
  logic        step_pulse;
  logic        sweep_done;
  logic [1:0]  state;
`ifdef GEN_MOD_SCHED_WDOG_EN
  logic        wdog_err;
`endif

  int checks = 0;
  int errors = 0;

  gen_mod_sched dut (
    .clk(clk), .rst(rst), .cfg_hp(cfg_hp), .cfg_phase(cfg_phase), .cfg_wr(cfg_wr),
    .sweep_start(sweep_start), .sweep_stop(sweep_stop), .sweep_step(sweep_step),
    .sweep_end(sweep_end), .sweep_dwell(sweep_dwell), .harmonic_trig(harmonic_trig),
    .hp(hp), .phase(phase), .gen_rst(gen_rst), .busy(busy), .cfg_err(cfg_err),
    .step_pulse(step_pulse), .sweep_done(sweep_done), .state(state)
`ifdef GEN_MOD_SCHED_WDOG_EN
    , .wdog_err(wdog_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        wr;
    logic [13:0] c_hp;
    logic [11:0] c_ph;
    logic        trig;
    logic [1:0]  e_st;
    logic [13:0] e_hp;
    logic [11:0] e_ph;
    logic        e_grst;
    logic        e_cerr;
  } vec_t;

  vec_t vecs [30];

  int exp_ph [6] = '{10, 35, 35, 60, 60, 60};
  int exp_sp [6] = '{0, 1, 0, 1, 0, 0};
  int exp_sd [6] = '{0, 0, 0, 0, 0, 1};
  int exp_st [6] = '{3, 3, 3, 3, 3, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input int stp, input int en, input int dw);
    sweep_step  = 12'(stp);
    sweep_end   = 12'(en);
    sweep_dwell = 16'(dw);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    check("sweep entry state", 32'(state), 32'd3);
  endtask

  task automatic trig_once();
    harmonic_trig = 1'b1;
    tick();
    harmonic_trig = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int stray;
    int n;
    rst = 1'b1; cfg_hp = '0; cfg_phase = '0; cfg_wr = 1'b0;
    sweep_start = 1'b0; sweep_stop = 1'b0; sweep_step = '0; sweep_end = '0;
    sweep_dwell = '0; harmonic_trig = 1'b0;

    //              rst wr hp  ph  trig  st hp ph  grst cerr
    for (int i = 0; i < 5; i++) vecs[i] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[5]  = '{0, 0, 0,   0, 0,  0, 0,   0, 1, 0};
    vecs[6]  = '{0, 1, 3,  40, 0,  0, 0,   0, 0, 1};
    vecs[7]  = '{0, 0, 0,   0, 0,  0, 0,   0, 0, 0};
    vecs[8]  = '{0, 1, 3,  40, 0,  1, 3,  40, 1, 0};
    vecs[9]  = '{0, 0, 0,   0, 0,  1, 3,  40, 1, 0};
    vecs[10] = '{0, 0, 0,   0, 0,  0, 3,  40, 0, 0};
    vecs[11] = '{0, 1, 3, 200, 0,  2, 3,  40, 0, 0};
    vecs[12] = '{0, 0, 0,   0, 0,  2, 3,  40, 0, 0};
    vecs[13] = '{0, 1, 5,   0, 0,  2, 3,  40, 0, 1};
    vecs[14] = '{0, 0, 0,   0, 1,  0, 3, 119, 0, 0};
    vecs[15] = '{0, 1, 3, 119, 0,  2, 3, 119, 0, 0};
    vecs[16] = '{0, 0, 0,   0, 1,  0, 3, 119, 0, 0};
    vecs[17] = '{0, 0, 0,   0, 1,  0, 3, 119, 0, 0};
    vecs[18] = '{0, 1, 0, 119, 0,  1, 0, 119, 1, 0};
    vecs[19] = '{0, 0, 0,   0, 1,  1, 0, 119, 1, 0};
    vecs[20] = '{0, 0, 0,   0, 0,  0, 0, 119, 0, 0};
    vecs[21] = '{0, 1, 7,  20, 0,  1, 7,  20, 1, 0};
    vecs[22] = '{1, 0, 0,   0, 0,  0, 0,   0, 1, 0};
    vecs[23] = '{0, 0, 0,   0, 0,  0, 0,   0, 1, 0};
    vecs[24] = '{0, 0, 0,   0, 0,  0, 0,   0, 0, 0};
    vecs[25] = '{0, 1, 3, 120, 0,  1, 3, 119, 1, 0};
    vecs[26] = '{0, 0, 0,   0, 0,  1, 3, 119, 1, 0};
    vecs[27] = '{0, 0, 0,   0, 0,  0, 3, 119, 0, 0};
    vecs[28] = '{0, 1, 3,  10, 0,  2, 3, 119, 0, 0};
    vecs[29] = '{0, 0, 0,   0, 1,  0, 3,  10, 0, 0};

    for (int i = 0; i < 30; i++) begin
      rst = vecs[i].rst; cfg_wr = vecs[i].wr; cfg_hp = vecs[i].c_hp;
      cfg_phase = vecs[i].c_ph; harmonic_trig = vecs[i].trig;
      tick();
      check($sformatf("row%0d state", i),   32'(state),   32'(vecs[i].e_st));
      check($sformatf("row%0d hp", i),      32'(hp),      32'(vecs[i].e_hp));
      check($sformatf("row%0d phase", i),   32'(phase),   32'(vecs[i].e_ph));
      check($sformatf("row%0d gen_rst", i), 32'(gen_rst), 32'(vecs[i].e_grst));
      check($sformatf("row%0d cfg_err", i), 32'(cfg_err), 32'(vecs[i].e_cerr));
      check($sformatf("row%0d busy", i),    32'(busy),    32'(vecs[i].e_st != 2'd0));
    end
    rst = 1'b0; cfg_wr = 1'b0; harmonic_trig = 1'b0;

    // sweep 10 -> 35 -> 60 -> done, dwell 2, trig every 50 clocks
    start_sweep(25, 60, 2);
    check("sweep entry phase", 32'(phase), 32'd10);
    stray = 0;
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 49; k++) begin
        if (t == 2 && k == 10) begin
          cfg_wr = 1'b1; cfg_hp = 14'd9; cfg_phase = 12'd5;
        end
        tick();
        cfg_wr = 1'b0;
        if (t == 2 && k == 10) begin
          check("sweep cfg_wr cfg_err", 32'(cfg_err), 32'd1);
          check("sweep cfg_wr hp",      32'(hp),      32'd3);
          check("sweep cfg_wr phase",   32'(phase),   32'd35);
          check("sweep cfg_wr state",   32'(state),   32'd3);
        end else if (step_pulse || sweep_done || cfg_err) begin
          stray++;
        end
      end
      trig_once();
      check($sformatf("sweep trig%0d phase", t + 1), 32'(phase),      32'(exp_ph[t]));
      check($sformatf("sweep trig%0d step", t + 1),  32'(step_pulse), 32'(exp_sp[t]));
      check($sformatf("sweep trig%0d done", t + 1),  32'(sweep_done), 32'(exp_sd[t]));
      check($sformatf("sweep trig%0d state", t + 1), 32'(state),      32'(exp_st[t]));
    end
    check("sweep stray pulses", 32'(stray), 32'd0);
    tick();
    check("sweep done width", 32'(sweep_done), 32'd0);

    // stop coincident with dwell expiry; dwell 0 acts as 1
    start_sweep(10, 100, 0);
    trig_once();
    check("stop seq first step phase", 32'(phase), 32'd70);
    check("stop seq first step pulse", 32'(step_pulse), 32'd1);
    tick(); tick();
    sweep_stop = 1'b1; harmonic_trig = 1'b1;
    tick();
    sweep_stop = 1'b0; harmonic_trig = 1'b0;
    check("stop+trig state", 32'(state), 32'd0);
    check("stop+trig phase", 32'(phase), 32'd70);
    check("stop+trig step", 32'(step_pulse), 32'd0);
    check("stop+trig done", 32'(sweep_done), 32'd0);
    tick();
    check("stop+trig no late done", 32'(sweep_done), 32'd0);

    // end below start: single downward jump to lim, then done
    start_sweep(5, 30, 1);
    trig_once();
    check("end<start phase", 32'(phase), 32'd30);
    check("end<start step", 32'(step_pulse), 32'd1);
    trig_once();
    check("end<start done", 32'(sweep_done), 32'd1);
    check("end<start state", 32'(state), 32'd0);

    // zero step finishes after first dwell
    start_sweep(0, 100, 1);
    trig_once();
    check("step0 done", 32'(sweep_done), 32'd1);
    check("step0 phase", 32'(phase), 32'd30);
    check("step0 step", 32'(step_pulse), 32'd0);

    // sweep_end beyond the period clamps to PERIOD_LEN-1
    start_sweep(50, 4000, 1);
    trig_once();
    check("clamp step1 phase", 32'(phase), 32'd80);
    trig_once();
    check("clamp step2 phase", 32'(phase), 32'd119);
    check("clamp step2 pulse", 32'(step_pulse), 32'd1);
    trig_once();
    check("clamp done", 32'(sweep_done), 32'd1);
    check("clamp done phase", 32'(phase), 32'd119);

    // plain stop, no done
    start_sweep(1, 100, 1);
    sweep_stop = 1'b1;
    tick();
    sweep_stop = 1'b0;
    check("plain stop state", 32'(state), 32'd0);
    check("plain stop done", 32'(sweep_done), 32'd0);

    // sweep_start ignored while in APPLY
    cfg_wr = 1'b1; cfg_hp = 14'd3; cfg_phase = 12'd0;
    tick();
    cfg_wr = 1'b0;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    check("start in APPLY ignored", 32'(state), 32'd2);
    trig_once();
    check("apply after ignored start state", 32'(state), 32'd0);
    check("apply after ignored start phase", 32'(phase), 32'd0);

`ifdef GEN_MOD_SCHED_WDOG_EN
    cfg_wr = 1'b1; cfg_hp = 14'd0; cfg_phase = 12'd0;
    tick();
    cfg_wr = 1'b0;
    tick(); tick();
    check("wdog setup state", 32'(state), 32'd0);
    cfg_wr = 1'b1; cfg_hp = 14'd0; cfg_phase = 12'd5;
    tick();
    cfg_wr = 1'b0;
    check("wdog apply state", 32'(state), 32'd2);
    n = 0;
    for (int c = 1; c <= 400; c++) begin
      tick();
      if (wdog_err) begin
        n = c;
        break;
      end
    end
    check("wdog expiry clock", 32'(n), 32'd240);
    check("wdog restart state", 32'(state), 32'd1);
    check("wdog gen_rst", 32'(gen_rst), 32'd1);
    check("wdog phase kept", 32'(phase), 32'd0);
    tick();
    check("wdog pulse width", 32'(wdog_err), 32'd0);
    check("wdog gen_rst 2nd", 32'(gen_rst), 32'd1);
    tick();
    check("wdog back idle", 32'(state), 32'd0);
    check("wdog gen_rst off", 32'(gen_rst), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
